// File: rtl/bus_mux_arb_pkg.sv
// Shared constants for the core data-bus multiplexer.
// Mode encodings and default geometry live here.
package core_bus_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_NUM_SRC = 11;

endpackage

// File: rtl/bus_mux_arb_if.sv
// Bus-side bundle of the data-bus multiplexer: select, sources,
// grants and the registered output handshake.
interface bus_mux_arb_if #(
    parameter int DATA_W  = 16,
    parameter int NUM_SRC = 11,
    parameter int SEL_W   = $clog2(NUM_SRC)
);

    logic                      mode;
    logic                      enable;
    logic [SEL_W-1:0]          select;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_req;
    logic [NUM_SRC-1:0]        grant;
    logic [DATA_W-1:0]         data_out;
    logic                      out_valid;
    logic                      out_ready;
    logic [SEL_W-1:0]          out_src;
    logic                      sel_err;

    modport slave (
        input  mode, enable, select, src_data, src_req, out_ready,
        output grant, data_out, out_valid, out_src, sel_err
    );

    modport master (
        output mode, enable, select, src_data, src_req, out_ready,
        input  grant, data_out, out_valid, out_src, sel_err
    );

endinterface

// File: rtl/bus_mux_arb_rr_arbiter.sv
// Rotating-priority arbiter: search starts at ptr and wraps,
// ptr moves past the winner whenever the top commits a capture.
module rr_arbiter #(
    parameter int NUM_SRC = 11,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic               advance,
    output logic [NUM_SRC-1:0] grant,
    output logic [SEL_W-1:0]   winner,
    output logic               found
);

    logic [SEL_W-1:0] ptr_q, ptr_d;

    always_comb begin
        int j;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_SRC) j = j - NUM_SRC;
            if (!found && req[j]) begin
                found  = 1'b1;
                winner = SEL_W'(j);
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            grant[i] = found && (winner == SEL_W'(i));
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (winner == SEL_W'(NUM_SRC - 1)) ? '0
                                                   : winner + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

endmodule

// File: rtl/bus_mux_arb.sv
// Core data-bus multiplexer: direct or round-robin source selection
// into a single registered output slot with valid/ready handshake.
module bus_mux_arb
    import core_bus_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input logic        clk,
    input logic        rst,
    bus_mux_arb_if.slave bus
);

    logic                can_load;
    logic                sel_ok;
    logic                cap;
    logic [NUM_SRC-1:0]  dir_hit;
    logic [NUM_SRC-1:0]  gnt;
    logic [NUM_SRC-1:0]  rr_grant;
    logic [SEL_W-1:0]    rr_winner;
    logic                rr_found;
    logic                rr_adv;
    logic [DATA_W-1:0]   cap_word;
    logic [SEL_W-1:0]    cap_idx;

    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                out_valid_q, out_valid_d;
    logic [SEL_W-1:0]    out_src_q, out_src_d;
    logic                sel_err_q, sel_err_d;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.src_req),
        .advance (rr_adv),
        .grant   (rr_grant),
        .winner  (rr_winner),
        .found   (rr_found)
    );

    // Grant is combinational and forced low while reset is held.
    always_comb begin
        can_load = bus.enable & (~out_valid_q | bus.out_ready);
        dir_hit  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            dir_hit[i] = (bus.select == SEL_W'(i));
        end
        sel_ok = |dir_hit;
        gnt    = '0;
        if (rst && can_load) begin
            if (bus.mode == MODE_RR) gnt = rr_grant;
            else                     gnt = dir_hit & bus.src_req;
        end
    end

    always_comb begin
        cap_word = '0;
        cap_idx  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt[i]) begin
                cap_word = cap_word | bus.src_data[i*DATA_W +: DATA_W];
                cap_idx  = cap_idx | SEL_W'(i);
            end
        end
        cap    = |gnt;
        rr_adv = cap & (bus.mode == MODE_RR) & rr_found;
    end

    always_comb begin
        data_out_d  = cap ? cap_word : data_out_q;
        out_src_d   = cap ? cap_idx  : out_src_q;
        out_valid_d = cap | (out_valid_q & ~bus.out_ready);
        sel_err_d   = can_load & (bus.mode == MODE_DIRECT) & ~sel_ok;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign bus.grant     = gnt;
    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_src   = out_src_q;
    assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_bus_mux_arb.sv
// Directed bench for bus_mux_arb: default 16x11 instance plus a
// 32x4 instance for the parametrised checks.
module tb_bus_mux_arb;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bus_mux_arb_if #(.DATA_W(16), .NUM_SRC(11)) if_a ();
    bus_mux_arb_if #(.DATA_W(32), .NUM_SRC(4))  if_b ();

    bus_mux_arb #(.DATA_W(16), .NUM_SRC(11)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    bus_mux_arb #(.DATA_W(32), .NUM_SRC(4)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int rr_seq_a [5] = '{0, 4, 10, 0, 4};
    int rr_seq_b [3] = '{10, 0, 10};

    initial begin
        if_a.mode = 1'b0; if_a.enable = 1'b0; if_a.select = '0;
        if_a.src_data = '0; if_a.src_req = '0; if_a.out_ready = 1'b0;
        if_b.mode = 1'b0; if_b.enable = 1'b0; if_b.select = '0;
        if_b.src_data = '0; if_b.src_req = '0; if_b.out_ready = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", 64'(if_a.data_out), 64'd0);
        chk("rst_valid", 64'(if_a.out_valid), 64'd0);
        chk("rst_src", 64'(if_a.out_src), 64'd0);
        chk("rst_err", 64'(if_a.sel_err), 64'd0);
        rst = 1'b1;

        // load 250, then reset mid-transfer
        if_a.enable = 1'b1;
        if_a.src_data[0 +: 16] = 16'd250;
        if_a.src_req = 11'h001;
        step();
        chk("pre_data", 64'(if_a.data_out), 64'd250);
        chk("pre_valid", 64'(if_a.out_valid), 64'd1);
        #3 rst = 1'b0;
        #1;
        chk("mid_data", 64'(if_a.data_out), 64'd0);
        chk("mid_valid", 64'(if_a.out_valid), 64'd0);
        chk("mid_grant", 64'(if_a.grant), 64'd0);
        step();
        rst = 1'b1;
        #1;
        chk("rel_ptr", 64'(u_a.u_arb.ptr_q), 64'd0);
        chk("rel_grant", 64'(if_a.grant), 64'd1);

        // direct capture
        if_a.src_req = '0;
        for (int i = 0; i < 11; i++) if_a.src_data[i*16 +: 16] = 16'(310 + i);
        if_a.out_ready = 1'b1;
        if_a.select = 4'd3;
        if_a.src_req = 11'h008;
        #1;
        chk("dir_grant", 64'(if_a.grant), 64'h008);
        step();
        chk("dir_data", 64'(if_a.data_out), 64'd313);
        chk("dir_src", 64'(if_a.out_src), 64'd3);
        chk("dir_valid", 64'(if_a.out_valid), 64'd1);
        for (int s = 0; s < 11; s++) begin
            if_a.select = 4'(s);
            if_a.src_req = 11'(1 << s);
            step();
            chk("sweep_data", 64'(if_a.data_out), 64'(310 + s));
            chk("sweep_src", 64'(if_a.out_src), 64'(s));
        end

        // out-of-range select
        if_a.select = 4'd11;
        if_a.src_req = '1;
        #1;
        chk("oor_grant", 64'(if_a.grant), 64'd0);
        step();
        chk("oor_err", 64'(if_a.sel_err), 64'd1);
        chk("oor_valid", 64'(if_a.out_valid), 64'd0);
        chk("oor_data", 64'(if_a.data_out), 64'd320);
        if_a.select = 4'd3;
        if_a.src_req = '0;
        step();
        chk("oor_err_clr", 64'(if_a.sel_err), 64'd0);

        // backpressure
        if_a.src_data[3*16 +: 16] = 16'd311;
        if_a.src_req = 11'h008;
        step();
        chk("bp_load", 64'(if_a.data_out), 64'd311);
        if_a.out_ready = 1'b0;
        if_a.src_data[3*16 +: 16] = 16'd999;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_grant", 64'(if_a.grant), 64'd0);
            step();
            chk("bp_data", 64'(if_a.data_out), 64'd311);
            chk("bp_valid", 64'(if_a.out_valid), 64'd1);
        end
        if_a.out_ready = 1'b1;
        #1;
        chk("bp_rel_grant", 64'(if_a.grant), 64'h008);
        step();
        chk("bp_rel_data", 64'(if_a.data_out), 64'd999);
        if_a.src_req = '0;
        step();
        chk("drain_valid", 64'(if_a.out_valid), 64'd0);
        chk("drain_data", 64'(if_a.data_out), 64'd999);

        // round-robin fairness
        if_a.mode = 1'b1;
        if_a.select = 4'd11;
        if_a.src_req = 11'h411;
        #1;
        chk("rr_grant0", 64'(if_a.grant), 64'h001);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_src", 64'(if_a.out_src), 64'(rr_seq_a[k]));
            chk("rr_data", 64'(if_a.data_out), 64'(310 + rr_seq_a[k]));
            chk("rr_no_err", 64'(if_a.sel_err), 64'd0);
        end
        if_a.src_req = 11'h401;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rr2_src", 64'(if_a.out_src), 64'(rr_seq_b[k]));
        end

        // enable low: no grant, held word drains
        if_a.enable = 1'b0;
        #1;
        chk("en_grant", 64'(if_a.grant), 64'd0);
        step();
        chk("en_valid", 64'(if_a.out_valid), 64'd0);
        chk("en_src", 64'(if_a.out_src), 64'd10);

        // direct capture leaves ptr (0) untouched
        if_a.enable = 1'b1;
        if_a.mode = 1'b0;
        if_a.select = 4'd1;
        if_a.src_req = 11'h002;
        step();
        chk("mc_dir_src", 64'(if_a.out_src), 64'd1);
        if_a.mode = 1'b1;
        if_a.src_req = 11'h401;
        step();
        chk("mc_rr_src", 64'(if_a.out_src), 64'd0);
        if_a.enable = 1'b0;

        // 32-bit, 4-source instance
        if_b.enable = 1'b1;
        if_b.out_ready = 1'b1;
        if_b.src_data[0*32 +: 32] = 32'h1111_1111;
        if_b.src_data[2*32 +: 32] = 32'hDEAD_BEEF;
        if_b.src_data[3*32 +: 32] = 32'hCAFE_F00D;
        if_b.select = 2'd2;
        if_b.src_req = 4'b0100;
        step();
        chk("b_dir_data", 64'(if_b.data_out), 64'hDEAD_BEEF);
        chk("b_dir_src", 64'(if_b.out_src), 64'd2);
        if_b.select = 2'd3;
        if_b.src_req = 4'b1000;
        step();
        chk("b_sel3_data", 64'(if_b.data_out), 64'hCAFE_F00D);
        if_b.mode = 1'b1;
        if_b.src_req = 4'b0100;
        step();
        chk("b_rr_src2", 64'(if_b.out_src), 64'd2);
        if_b.src_req = 4'b0001;
        #1;
        chk("b_wrap_grant", 64'(if_b.grant), 64'b0001);
        step();
        chk("b_wrap_src", 64'(if_b.out_src), 64'd0);
        chk("b_wrap_data", 64'(if_b.data_out), 64'h1111_1111);
        if_b.src_req = 4'b1001;
        step();
        chk("b_rr_src3", 64'(if_b.out_src), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
